// File: rtl/io_port_pkg.sv
// Shared types and constants for the buffered CPU I/O port.
// Optional feature macro used by io_port_unit: IO_PORT_TIMEOUT_EN.
package io_port_pkg;

   localparam int unsigned DEFAULT_DEPTH  = 4;
   localparam int unsigned DEFAULT_WIDTH  = 16;
   localparam int unsigned TIMEOUT_CYCLES = 255;
   localparam int unsigned TIMER_W        = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_WAIT  = 2'd1,
      OUT_WAIT = 2'd2,
      ACK      = 2'd3
   } state_e;

endpackage

// File: rtl/io_port_if.sv
// CPU handshake and device stream bundle of the I/O port.
// slave = the port unit, master = CPU plus board-level devices.
interface io_port_if #(
   parameter int unsigned DEPTH = io_port_pkg::DEFAULT_DEPTH,
   parameter int unsigned WIDTH = io_port_pkg::DEFAULT_WIDTH
) ();

   logic                    cpu_in_req;
   logic [WIDTH-1:0]        cpu_in_data;
   logic                    cpu_in_ack;
   logic                    cpu_out_req;
   logic [WIDTH-1:0]        cpu_out_data;
   logic                    cpu_out_ack;
   logic                    cpu_timeout;
   logic                    ext_in_valid;
   logic                    ext_in_ready;
   logic [WIDTH-1:0]        ext_in_data;
   logic                    ext_out_valid;
   logic                    ext_out_ready;
   logic [WIDTH-1:0]        ext_out_data;
   logic [$clog2(DEPTH):0]  in_count;
   logic [$clog2(DEPTH):0]  out_count;

   modport slave (
      input  cpu_in_req, cpu_out_req, cpu_out_data,
      input  ext_in_valid, ext_in_data, ext_out_ready,
      output cpu_in_data, cpu_in_ack, cpu_out_ack, cpu_timeout,
      output ext_in_ready, ext_out_valid, ext_out_data,
      output in_count, out_count
   );

   modport master (
      output cpu_in_req, cpu_out_req, cpu_out_data,
      output ext_in_valid, ext_in_data, ext_out_ready,
      input  cpu_in_data, cpu_in_ack, cpu_out_ack, cpu_timeout,
      input  ext_in_ready, ext_out_valid, ext_out_data,
      input  in_count, out_count
   );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with registered occupancy and combinational head word.
// Push when full and pop when empty are ignored; storage is not reset.
module io_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/io_port_unit.sv
// Buffered I/O port servicing the CPU IN/OUT handshake over two FIFOs.
// Define IO_PORT_TIMEOUT_EN to force-ack requests stuck waiting too long.
module io_port_unit
   import io_port_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic      clock,
   input logic      reset,
   io_port_if.slave bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e           state;
   state_e           state_next;

   logic             in_push, in_pop, in_full, in_empty;
   logic             out_push, out_pop, out_full, out_empty;
   logic [WIDTH-1:0] in_head, out_head;
   logic [CW-1:0]    in_cnt, out_cnt;

   logic             in_ack_d, out_ack_d, timeout_d, data_load, expired;
   logic [WIDTH-1:0] data_d;
   logic             in_ack_q, out_ack_q, timeout_q;
   logic [WIDTH-1:0] in_data_q;

   assign in_push = bus.ext_in_valid && !in_full;
   assign out_pop = bus.ext_out_ready && !out_empty;

   io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
      .clock (clock),
      .reset (reset),
      .push  (in_push),
      .pop   (in_pop),
      .wdata (bus.ext_in_data),
      .rdata (in_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_cnt)
   );

   io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
      .clock (clock),
      .reset (reset),
      .push  (out_push),
      .pop   (out_pop),
      .wdata (bus.cpu_out_data),
      .rdata (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_cnt)
   );

`ifdef IO_PORT_TIMEOUT_EN
   // Counts cycles spent waiting; zero whenever outside the wait states
   logic [TIMER_W-1:0] timer;

   always_ff @(posedge clock) begin
      if (reset || (state != IN_WAIT && state != OUT_WAIT)) timer <= '0;
      else                                                  timer <= timer + TIMER_W'(1);
   end

   assign expired = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         in_ack_q  <= 1'b0;
         out_ack_q <= 1'b0;
         timeout_q <= 1'b0;
         in_data_q <= '0;
      end else begin
         state     <= state_next;
         in_ack_q  <= in_ack_d;
         out_ack_q <= out_ack_d;
         timeout_q <= timeout_d;
         if (data_load) in_data_q <= data_d;
      end
   end

   // FIFO full/empty come from registered counts: no same-cycle bypass
   always_comb begin
      state_next = state;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      in_ack_d   = 1'b0;
      out_ack_d  = 1'b0;
      timeout_d  = 1'b0;
      data_load  = 1'b0;
      data_d     = in_head;
      case (state)
         IDLE: begin
            if (bus.cpu_in_req) begin
               if (!in_empty) begin
                  in_pop     = 1'b1;
                  data_load  = 1'b1;
                  in_ack_d   = 1'b1;
                  state_next = ACK;
               end else begin
                  state_next = IN_WAIT;
               end
            end else if (bus.cpu_out_req) begin
               if (!out_full) begin
                  out_push   = 1'b1;
                  out_ack_d  = 1'b1;
                  state_next = ACK;
               end else begin
                  state_next = OUT_WAIT;
               end
            end
         end
         IN_WAIT: begin
            if (!in_empty) begin
               in_pop     = 1'b1;
               data_load  = 1'b1;
               in_ack_d   = 1'b1;
               state_next = ACK;
            end else if (expired) begin
               data_load  = 1'b1;
               data_d     = '0;
               in_ack_d   = 1'b1;
               timeout_d  = 1'b1;
               state_next = ACK;
            end
         end
         OUT_WAIT: begin
            if (!out_full) begin
               out_push   = 1'b1;
               out_ack_d  = 1'b1;
               state_next = ACK;
            end else if (expired) begin
               out_ack_d  = 1'b1;
               timeout_d  = 1'b1;
               state_next = ACK;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.cpu_in_data   = in_data_q;
   assign bus.cpu_in_ack    = in_ack_q;
   assign bus.cpu_out_ack   = out_ack_q;
   assign bus.cpu_timeout   = timeout_q;
   assign bus.ext_in_ready  = !in_full;
   assign bus.ext_out_valid = !out_empty;
   assign bus.ext_out_data  = out_head;
   assign bus.in_count      = in_cnt;
   assign bus.out_count     = out_cnt;

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: cycle vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_io_port_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WIDTH = 16;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   io_port_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   io_port_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        in_req;
      logic        out_req;
      logic [15:0] out_data;
      logic        ei_valid;
      logic [15:0] ei_data;
      logic        eo_ready;
      logic        x_in_ack;
      logic        x_out_ack;
      logic [15:0] x_in_data;
      int          x_in_count;
      int          x_out_count;
      logic        x_eo_valid;
      logic [15:0] x_eo_data;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sink[$];

   // Device-side receiver: a word transfers at the edge following valid&&ready
   always @(negedge clock) begin
      if (!reset && bus.ext_out_valid && bus.ext_out_ready) sink.push_back(bus.ext_out_data);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_in_req    = 1'b0;
      bus.cpu_out_req   = 1'b0;
      bus.cpu_out_data  = 16'h0;
      bus.ext_in_valid  = 1'b0;
      bus.ext_in_data   = 16'h0;
      bus.ext_out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      sink.delete();
   endtask

   function automatic vec_t mk(logic ir, logic orq, logic [15:0] od, logic ev, logic [15:0] ed,
                               logic er, logic xia, logic xoa, logic [15:0] xid, int xic,
                               int xoc, logic xov, logic [15:0] xod);
      vec_t v;
      v.in_req = ir;   v.out_req = orq;  v.out_data = od;
      v.ei_valid = ev; v.ei_data = ed;   v.eo_ready = er;
      v.x_in_ack = xia; v.x_out_ack = xoa; v.x_in_data = xid;
      v.x_in_count = xic; v.x_out_count = xoc; v.x_eo_valid = xov; v.x_eo_data = xod;
      return v;
   endfunction

   logic [15:0] exp_in[$];
   logic [15:0] exp_out[$];
   logic [15:0] exp_word;
   logic [15:0] out_word;
   bit          in_pend, out_pend;
   int          acks, waited, wd;

   initial begin
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;

      check("rst_in_ack",    32'(bus.cpu_in_ack), 32'd0);
      check("rst_out_ack",   32'(bus.cpu_out_ack), 32'd0);
      check("rst_timeout",   32'(bus.cpu_timeout), 32'd0);
      check("rst_in_data",   32'(bus.cpu_in_data), 32'h0);
      check("rst_in_count",  32'(bus.in_count), 32'd0);
      check("rst_out_count", 32'(bus.out_count), 32'd0);
      check("rst_in_ready",  32'(bus.ext_in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.ext_out_valid), 32'd0);

      // in_req out_req out_data ev ed er | in_ack out_ack in_data in_cnt out_cnt eo_valid eo_data
      vecs.push_back(mk(0,0,16'h0000,1,16'hA5A5,0, 0,0,16'h0000,1,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,1,16'h1234,0, 0,0,16'h0000,2,0,0,16'h0));
      vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0, 1,0,16'hA5A5,1,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'hA5A5,1,0,0,16'h0));
      vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0, 1,0,16'h1234,0,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h1234,0,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,1,16'h0BEE,0, 0,0,16'h1234,1,0,0,16'h0));
      vecs.push_back(mk(1,1,16'hC0DE,0,16'h0000,0, 1,0,16'h0BEE,0,0,0,16'h0));
      vecs.push_back(mk(0,1,16'hC0DE,0,16'h0000,0, 0,0,16'h0BEE,0,0,0,16'h0));
      vecs.push_back(mk(0,1,16'hC0DE,0,16'h0000,0, 0,1,16'h0BEE,0,1,1,16'hC0DE));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,16'h0BEE,0,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,1,16'h1111,0, 0,0,16'h0BEE,1,0,0,16'h0));
      vecs.push_back(mk(1,0,16'h0000,1,16'h2222,0, 1,0,16'h1111,1,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h1111,1,0,0,16'h0));
      vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0, 1,0,16'h2222,0,0,0,16'h0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h2222,0,0,0,16'h0));
      vecs.push_back(mk(0,1,16'hDEAD,0,16'h0000,1, 0,1,16'h2222,0,1,1,16'hDEAD));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h2222,0,1,1,16'hDEAD));
      vecs.push_back(mk(0,1,16'hBEEF,0,16'h0000,1, 0,1,16'h2222,0,1,1,16'hBEEF));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,16'h2222,0,0,0,16'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         bus.cpu_in_req    = vecs[i].in_req;
         bus.cpu_out_req   = vecs[i].out_req;
         bus.cpu_out_data  = vecs[i].out_data;
         bus.ext_in_valid  = vecs[i].ei_valid;
         bus.ext_in_data   = vecs[i].ei_data;
         bus.ext_out_ready = vecs[i].eo_ready;
         step();
         check($sformatf("vec%0d_in_ack", i),    32'(bus.cpu_in_ack),  32'(vecs[i].x_in_ack));
         check($sformatf("vec%0d_out_ack", i),   32'(bus.cpu_out_ack), 32'(vecs[i].x_out_ack));
         check($sformatf("vec%0d_in_data", i),   32'(bus.cpu_in_data), 32'(vecs[i].x_in_data));
         check($sformatf("vec%0d_in_count", i),  32'(bus.in_count),    32'(vecs[i].x_in_count));
         check($sformatf("vec%0d_out_count", i), 32'(bus.out_count),   32'(vecs[i].x_out_count));
         check($sformatf("vec%0d_in_ready", i),  32'(bus.ext_in_ready),
               32'(vecs[i].x_in_count != int'(DEPTH)));
         check($sformatf("vec%0d_out_valid", i), 32'(bus.ext_out_valid), 32'(vecs[i].x_eo_valid));
         check($sformatf("vec%0d_timeout", i),   32'(bus.cpu_timeout), 32'd0);
         if (vecs[i].x_eo_valid)
            check($sformatf("vec%0d_out_data", i), 32'(bus.ext_out_data), 32'(vecs[i].x_eo_data));
      end
      idle_inputs();

      // IN on empty FIFO; device word arrives 5 cycles later
      bus.cpu_in_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         acks += int'(bus.cpu_in_ack);
      end
      check("inwait_no_early_ack", 32'(acks), 32'd0);
      bus.ext_in_valid = 1'b1;
      bus.ext_in_data  = 16'h00FF;
      step();
      bus.ext_in_valid = 1'b0;
      check("inwait_ack_after_edge_plus1", 32'(bus.cpu_in_ack), 32'd0);
      step();
      check("inwait_ack", 32'(bus.cpu_in_ack), 32'd1);
      check("inwait_data", 32'(bus.cpu_in_data), 32'h00FF);
      check("inwait_count", 32'(bus.in_count), 32'd0);
      bus.cpu_in_req = 1'b0;
      step();
      check("inwait_ack_drop", 32'(bus.cpu_in_ack), 32'd0);

      // Five OUTs into a four-deep FIFO with the device stalled
      sink.delete();
      bus.ext_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.cpu_out_req  = 1'b1;
         bus.cpu_out_data = 16'(16'h5000 + k);
         step();
         check($sformatf("fill%0d_ack", k), 32'(bus.cpu_out_ack), 32'd1);
         bus.cpu_out_req = 1'b0;
         step();
         check($sformatf("fill%0d_count", k), 32'(bus.out_count), 32'(k + 1));
      end
      bus.cpu_out_req  = 1'b1;
      bus.cpu_out_data = 16'h5004;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         acks += int'(bus.cpu_out_ack);
      end
      check("stall_no_ack", 32'(acks), 32'd0);
      check("stall_count", 32'(bus.out_count), 32'd4);
      check("stall_in_ready", 32'(bus.ext_in_ready), 32'd1);
      bus.ext_out_ready = 1'b1;
      acks = 0;
      for (int i = 0; i < 10 && acks == 0; i++) begin
         step();
         acks += int'(bus.cpu_out_ack);
      end
      check("stall_release_ack", 32'(acks), 32'd1);
      bus.cpu_out_req = 1'b0;
      for (int i = 0; i < 20 && bus.out_count != 0; i++) step();
      check("drain_count", 32'(bus.out_count), 32'd0);
      check("drain_words", 32'(sink.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         exp_word = 16'(16'h5000 + k);
         out_word = (k < sink.size()) ? sink[k] : 16'hxxxx;
         check($sformatf("drain_word%0d", k), 32'(out_word), 32'(exp_word));
      end
      idle_inputs();
      step();

      // Reset while the FSM is waiting in IN_WAIT
      bus.cpu_out_req  = 1'b1;
      bus.cpu_out_data = 16'h7777;
      step();
      bus.cpu_out_req = 1'b0;
      step();
      check("prerst_out_count", 32'(bus.out_count), 32'd1);
      bus.cpu_in_req = 1'b1;
      step();
      step();
      step();
      reset = 1'b1;
      bus.cpu_in_req = 1'b0;
      step();
      reset = 1'b0;
      check("midrst_in_ack", 32'(bus.cpu_in_ack), 32'd0);
      check("midrst_out_ack", 32'(bus.cpu_out_ack), 32'd0);
      check("midrst_in_data", 32'(bus.cpu_in_data), 32'h0);
      check("midrst_in_count", 32'(bus.in_count), 32'd0);
      check("midrst_out_count", 32'(bus.out_count), 32'd0);
      check("midrst_out_valid", 32'(bus.ext_out_valid), 32'd0);
      bus.ext_in_valid = 1'b1;
      bus.ext_in_data  = 16'h4242;
      step();
      bus.ext_in_valid = 1'b0;
      check("midrst_push_count", 32'(bus.in_count), 32'd1);
      step();
      check("midrst_no_stale_ack", 32'(bus.cpu_in_ack), 32'd0);
      check("midrst_word_kept", 32'(bus.in_count), 32'd1);
      bus.cpu_in_req = 1'b1;
      step();
      check("midrst_idle_ack", 32'(bus.cpu_in_ack), 32'd1);
      check("midrst_idle_data", 32'(bus.cpu_in_data), 32'h4242);
      bus.cpu_in_req = 1'b0;
      step();

      // Timeout behaviour on an IN that never gets data
      do_reset();
      bus.cpu_in_req = 1'b1;
      acks = 0;
      waited = 0;
      for (int i = 0; i < 300 && acks == 0; i++) begin
         step();
         waited++;
         acks += int'(bus.cpu_in_ack);
      end
`ifdef IO_PORT_TIMEOUT_EN
      check("to_ack_seen", 32'(acks), 32'd1);
      check("to_ack_cycle", 32'(waited), 32'd256);
      check("to_flag", 32'(bus.cpu_timeout), 32'd1);
      check("to_data", 32'(bus.cpu_in_data), 32'h0);
      bus.cpu_in_req = 1'b0;
      step();
      check("to_ack_drop", 32'(bus.cpu_in_ack), 32'd0);
      check("to_flag_drop", 32'(bus.cpu_timeout), 32'd0);
`else
      check("noto_no_ack", 32'(acks), 32'd0);
      check("noto_flag", 32'(bus.cpu_timeout), 32'd0);
`endif
      do_reset();

      // Randomized traffic against a queue model of both FIFOs
      exp_in.delete();
      exp_out.delete();
      in_pend  = 1'b0;
      out_pend = 1'b0;
      wd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (bus.cpu_in_ack) begin
            check("rnd_in_ack_expected", 32'(in_pend), 32'd1);
            exp_word = (exp_in.size() != 0) ? exp_in.pop_front() : 16'hxxxx;
            check("rnd_in_data", 32'(bus.cpu_in_data), 32'(exp_word));
            in_pend = 1'b0;
            bus.cpu_in_req = 1'b0;
            wd = 0;
         end
         if (bus.cpu_out_ack) begin
            check("rnd_out_ack_expected", 32'(out_pend), 32'd1);
            exp_out.push_back(out_word);
            out_pend = 1'b0;
            bus.cpu_out_req = 1'b0;
            wd = 0;
         end
         check("rnd_timeout", 32'(bus.cpu_timeout), 32'd0);
         check("rnd_in_count", 32'(bus.in_count), 32'(exp_in.size()));
         check("rnd_out_count", 32'(bus.out_count), 32'(exp_out.size()));
         check("rnd_in_ready", 32'(bus.ext_in_ready), 32'(exp_in.size() != DEPTH));
         check("rnd_out_valid", 32'(bus.ext_out_valid), 32'(exp_out.size() != 0));
         if (exp_out.size() != 0)
            check("rnd_out_data", 32'(bus.ext_out_data), 32'(exp_out[0]));

         if (!bus.cpu_in_ack && !bus.cpu_out_ack) begin
            if (!in_pend && $urandom_range(0, 3) == 0) begin
               in_pend = 1'b1;
               bus.cpu_in_req = 1'b1;
            end
            if (!out_pend && $urandom_range(0, 3) == 0) begin
               out_pend = 1'b1;
               out_word = 16'($urandom);
               bus.cpu_out_req  = 1'b1;
               bus.cpu_out_data = out_word;
            end
         end
         bus.ext_in_valid  = 1'($urandom_range(0, 1));
         bus.ext_in_data   = 16'($urandom);
         bus.ext_out_ready = ($urandom_range(0, 2) != 0);
         if (bus.ext_in_valid && bus.ext_in_ready) exp_in.push_back(bus.ext_in_data);
         if (bus.ext_out_valid && bus.ext_out_ready && exp_out.size() != 0)
            void'(exp_out.pop_front());

         if (in_pend || out_pend) wd++;
         if (wd > 200) begin
            check("rnd_watchdog", 32'(wd), 32'd0);
            break;
         end
         step();
      end
      idle_inputs();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
